// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller: EX operand bypass selects, load-use and MDU stalls, redirect flush.
// Optional statistics counters are built when HAZARD_STATS_EN is defined.
//
// state | meaning
// IDLE  | MDU free; a start from ID/EX loads the occupancy down-counter
// BUSY  | MDU occupied; counter runs down, terminal count ends the operation

module hazard_fwd_unit #(
   parameter int REG_AW  = 5,
   parameter int MDU_LAT = 32,
   parameter int CNT_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_mdu_use,
   input  logic [REG_AW-1:0] ex_rs,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_memread,
   input  logic              ex_mdu_start,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   input  logic [1:0]        npc_op,
   output logic [1:0]        fwd_a,
   output logic [1:0]        fwd_b,
   output logic              stall,
   output logic              bubble_ex,
   output logic              flush_id,
   output logic              mdu_busy,
   output logic              mdu_done
`ifdef HAZARD_STATS_EN
   ,
   output logic [CNT_W-1:0]  stat_lu_cnt,
   output logic [CNT_W-1:0]  stat_mdu_cnt,
   output logic [CNT_W-1:0]  stat_flush_cnt
`endif
);

   localparam int MCW = $clog2(MDU_LAT + 1);
   localparam logic [MCW-1:0] CNT_LOAD = MCW'(MDU_LAT - 1);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mdu_state_t;

   mdu_state_t     state, state_nxt;
   logic [MCW-1:0] cnt, cnt_nxt;
   logic           lu, mh, redirect;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // A start seen while BUSY is dropped; the counter keeps running down.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (ex_mdu_start) begin
               state_nxt = BUSY;
               cnt_nxt   = CNT_LOAD;
            end
         end
         BUSY: begin
            if (cnt == '0) state_nxt = IDLE;
            else           cnt_nxt   = cnt - 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mdu_busy = (state == BUSY);
      mdu_done = (state == BUSY) && (cnt == '0);
   end

   function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
      if (mem_regwrite && (mem_rd != '0) && (mem_rd == src))    return 2'b10;
      else if (wb_regwrite && (wb_rd != '0) && (wb_rd == src))  return 2'b01;
      else                                                      return 2'b00;
   endfunction

   always_comb begin
      fwd_a = fwd_sel(ex_rs);
      fwd_b = fwd_sel(ex_rt);
   end

   always_comb begin
      lu = ex_memread && (ex_rd != '0) &&
           ((id_use_rs && (id_rs == ex_rd)) || (id_use_rt && (id_rt == ex_rd)));
      mh       = mdu_busy && id_mdu_use;
      redirect = (npc_op != 2'b00);
   end

   // The ID instruction is wrong-path on a redirect, so its hazards are moot.
   always_comb begin
      stall     = 1'b0;
      bubble_ex = 1'b0;
      flush_id  = 1'b0;
      if (redirect) begin
         flush_id  = 1'b1;
         bubble_ex = 1'b1;
      end else if (lu || mh) begin
         stall     = 1'b1;
         bubble_ex = 1'b1;
      end
   end

`ifdef HAZARD_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_lu_cnt    <= '0;
         stat_mdu_cnt   <= '0;
         stat_flush_cnt <= '0;
      end else begin
         if (redirect)        stat_flush_cnt <= stat_flush_cnt + CNT_W'(1);
         if (!redirect && lu) stat_lu_cnt    <= stat_lu_cnt + CNT_W'(1);
         if (!redirect && mh) stat_mdu_cnt   <= stat_mdu_cnt + CNT_W'(1);
      end
   end
`else
   logic unused_cnt_w;
   assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit (MDU_LAT=4): directed steps then random stimulus against a reference model.
// Statistics outputs are checked when HAZARD_STATS_EN is defined.

module tb_hazard_fwd_unit;
   localparam int LAT = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
   logic       id_use_rs, id_use_rt, id_mdu_use, ex_memread, ex_mdu_start;
   logic       mem_regwrite, wb_regwrite;
   logic [1:0] npc_op;
   logic [1:0] fwd_a, fwd_b;
   logic       stall, bubble_ex, flush_id, mdu_busy, mdu_done;
`ifdef HAZARD_STATS_EN
   logic [31:0] stat_lu_cnt, stat_mdu_cnt, stat_flush_cnt;
`endif

   always #5 clk = ~clk;

   hazard_fwd_unit #(.REG_AW(5), .MDU_LAT(LAT), .CNT_W(32)) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
      .id_mdu_use(id_mdu_use), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_mdu_start(ex_mdu_start),
      .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
      .npc_op(npc_op), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall), .bubble_ex(bubble_ex),
      .flush_id(flush_id), .mdu_busy(mdu_busy), .mdu_done(mdu_done)
`ifdef HAZARD_STATS_EN
      , .stat_lu_cnt(stat_lu_cnt), .stat_mdu_cnt(stat_mdu_cnt), .stat_flush_cnt(stat_flush_cnt)
`endif
   );

   int n_chk = 0, n_pass = 0, n_fail = 0;
   int busy_left;                // remaining MDU occupancy cycles, 0 = free
   logic [31:0] m_lu, m_mdu, m_flush;

   function automatic logic [1:0] ref_fwd(input logic [4:0] r);
      if (mem_regwrite && mem_rd != 0 && mem_rd == r) return 2'b10;
      if (wb_regwrite && wb_rd != 0 && wb_rd == r)    return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic ref_lu();
      return ex_memread && ex_rd != 0 &&
             ((id_use_rs && id_rs == ex_rd) || (id_use_rt && id_rt == ex_rd));
   endfunction

   function automatic logic ref_mh();
      return (busy_left > 0) && id_mdu_use;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk = n_chk + 1;
      assert (obs === exp) n_pass = n_pass + 1;
      else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic redir, hz;
      redir = (npc_op != 0);
      hz    = ref_lu() || ref_mh();
      chk("fwd_a", fwd_a, ref_fwd(ex_rs));
      chk("fwd_b", fwd_b, ref_fwd(ex_rt));
      chk("stall", stall, !redir && hz);
      chk("bubble_ex", bubble_ex, redir || hz);
      chk("flush_id", flush_id, redir);
      chk("mdu_busy", mdu_busy, busy_left > 0);
      chk("mdu_done", mdu_done, busy_left == 1);
`ifdef HAZARD_STATS_EN
      chk("stat_lu", stat_lu_cnt, m_lu);
      chk("stat_mdu", stat_mdu_cnt, m_mdu);
      chk("stat_flush", stat_flush_cnt, m_flush);
`endif
   endtask

   task automatic model_tick();
      if (npc_op != 0) m_flush = m_flush + 1;
      else begin
         if (ref_lu()) m_lu = m_lu + 1;
         if (ref_mh()) m_mdu = m_mdu + 1;
      end
      if (busy_left > 0)     busy_left = busy_left - 1;
      else if (ex_mdu_start) busy_left = LAT;
   endtask

   task automatic model_reset();
      busy_left = 0;
      m_lu = 0; m_mdu = 0; m_flush = 0;
   endtask

   task automatic cycle();
      #1 check_all();
      @(posedge clk);
      model_tick();
      #1;
   endtask

   task automatic clear_in();
      id_rs = 0; id_rt = 0; ex_rs = 0; ex_rt = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
      id_use_rs = 0; id_use_rt = 0; id_mdu_use = 0; ex_memread = 0; ex_mdu_start = 0;
      mem_regwrite = 0; wb_regwrite = 0; npc_op = 0;
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      model_reset();
      #3;
      chk("rst_busy", mdu_busy, 1'b0);
      chk("rst_done", mdu_done, 1'b0);
      chk("rst_stall", stall, 1'b0);
      check_all();
      @(posedge clk); #1;
      rst = 1'b0;

      // forwarding priority and register zero
      mem_regwrite = 1; mem_rd = 8; wb_regwrite = 1; wb_rd = 8; ex_rs = 8; ex_rt = 9;
      #1 chk("fwd_prio_a", fwd_a, 2'b10);
      chk("fwd_prio_b", fwd_b, 2'b00);
      cycle();
      mem_rd = 3;
      #1 chk("fwd_wb_a", fwd_a, 2'b01);
      cycle();
      mem_rd = 0; wb_rd = 0; ex_rs = 0; ex_rt = 0;
      #1 chk("fwd_r0_a", fwd_a, 2'b00);
      chk("fwd_r0_b", fwd_b, 2'b00);
      cycle();
      clear_in();

      // load-use: one stall, then the bubble removes the load
      ex_memread = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1;
      #1 chk("lu_stall", stall, 1'b1);
      chk("lu_bubble", bubble_ex, 1'b1);
      cycle();
      ex_memread = 0;
      #1 chk("lu_release", stall, 1'b0);
      cycle();
      ex_memread = 1; id_use_rt = 0;
      #1 chk("lu_nouse", stall, 1'b0);
      cycle();
      clear_in();

      // MDU run with ID waiting on it and a repeated start at cycle 2
      id_mdu_use = 1;
      for (int c = 0; c < 7; c++) begin
         ex_mdu_start = (c == 0 || c == 2);
         #1 chk($sformatf("mdu_busy_c%0d", c), mdu_busy, (c >= 1 && c <= 4));
         chk($sformatf("mdu_done_c%0d", c), mdu_done, (c == 4));
         chk($sformatf("mdu_stall_c%0d", c), stall, (c >= 1 && c <= 4));
         cycle();
      end
      clear_in();

      // redirect beats load-use
      ex_memread = 1; ex_rd = 5; id_rt = 5; id_use_rt = 1; npc_op = 2'b01;
      #1 chk("redir_flush", flush_id, 1'b1);
      chk("redir_bubble", bubble_ex, 1'b1);
      chk("redir_stall", stall, 1'b0);
      cycle();
`ifdef HAZARD_STATS_EN
      chk("redir_stat_flush", stat_flush_cnt, m_flush);
      chk("redir_stat_lu", stat_lu_cnt, m_lu);
`endif
      clear_in();

      // asynchronous reset in the middle of a BUSY run
      ex_mdu_start = 1;
      cycle();
      ex_mdu_start = 0;
      cycle();
      #1 chk("pre_rst_busy", mdu_busy, 1'b1);
      rst = 1'b1;
      #1 chk("async_rst_busy", mdu_busy, 1'b0);
      chk("async_rst_done", mdu_done, 1'b0);
      model_reset();
      @(posedge clk); #1;
      rst = 1'b0;
      cycle();
      cycle();
      ex_mdu_start = 1;
      cycle();
      ex_mdu_start = 0;
      for (int i = 0; i < 6; i++) begin
         #1 chk($sformatf("restart_busy_%0d", i), mdu_busy, (i < LAT));
         chk($sformatf("restart_done_%0d", i), mdu_done, (i == LAT - 1));
         cycle();
      end

      // random traffic on a small register window to provoke matches
      for (int n = 0; n < 400; n++) begin
         id_rs = 5'($urandom_range(0, 3));  id_rt = 5'($urandom_range(0, 3));
         ex_rs = 5'($urandom_range(0, 3));  ex_rt = 5'($urandom_range(0, 3));
         ex_rd = 5'($urandom_range(0, 3));  mem_rd = 5'($urandom_range(0, 3));
         wb_rd = 5'($urandom_range(0, 3));
         id_use_rs = 1'($urandom % 2);      id_use_rt = 1'($urandom % 2);
         id_mdu_use = 1'($urandom % 2);     ex_memread = 1'($urandom % 2);
         mem_regwrite = 1'($urandom % 2);   wb_regwrite = 1'($urandom % 2);
         ex_mdu_start = ($urandom % 6 == 0);
         npc_op = ($urandom % 4 == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         cycle();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
